adapter_link_sched: RTL and testbench

- Credit-gated scheduler for the single adapter link shared by three requesters: write-command (wr), read-command (rd) and response (resp).
- Sits between the protocol-side FIFOs and the adapter core.
- Owns the link transmit credit counter and grants one requester at a time.
- Grant is held for a bounded burst, then rearbitrated.

---
 rtl/adapter_link_sched.sv | 167 ++++++++++++++++
 tb/tb_adapter_link_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adapter_link_sched.sv
// Credit-gated scheduler granting the shared adapter link to wr/rd/resp requesters.
// Optional per-class beat and stall statistics are enabled with ADAPTER_SCHED_STATS_EN.
module adapter_link_sched #(
    parameter int unsigned CRD_W     = 7,
    parameter int unsigned CRD_INIT  = 127,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             wr_req_i,
    input  logic             rd_req_i,
    input  logic             resp_req_i,
    input  logic             link_ready_i,
    input  logic             crd_return_i,
`ifdef ADAPTER_SCHED_STATS_EN
    input  logic             stats_clr_i,
    output logic [15:0]      wr_beats_o,
    output logic [15:0]      rd_beats_o,
    output logic [15:0]      resp_beats_o,
    output logic [15:0]      stall_cyc_o,
`endif
    output logic             wr_gnt_o,
    output logic             rd_gnt_o,
    output logic             resp_gnt_o,
    output logic             link_valid_o,
    output logic [CRD_W-1:0] credit_o,
    output logic [1:0]       sched_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [CRD_W-1:0] CRD_MAX    = CRD_W'(CRD_INIT);
    localparam logic [3:0]       BURST_LAST = 4'(MAX_BURST);

    state_e           state_q, state_d;
    logic [CRD_W-1:0] credit_q, credit_d;
    logic [3:0]       burst_q, burst_d;
    logic             rr_rd_q, rr_rd_d;
    logic             gnt_req;
    logic             link_valid;
    logic             accept;

    always_comb begin
        gnt_req = 1'b0;
        case (state_q)
            WR:      gnt_req = wr_req_i;
            RD:      gnt_req = rd_req_i;
            RESP:    gnt_req = resp_req_i;
            default: gnt_req = 1'b0;
        endcase

        link_valid = (state_q != IDLE) && gnt_req && (credit_q != '0);
        accept     = link_valid && link_ready_i;

        // A simultaneous accept and return cancel out; returns beyond CRD_INIT are dropped.
        credit_d = credit_q;
        if (accept && !crd_return_i) begin
            credit_d = credit_q - 1'b1;
        end else if (!accept && crd_return_i && (credit_q != CRD_MAX)) begin
            credit_d = credit_q + 1'b1;
        end

        state_d = state_q;
        rr_rd_d = rr_rd_q;
        burst_d = burst_q + 4'(accept);

        case (state_q)
            IDLE: begin
                burst_d = '0;
                if (enable && (credit_q != '0)) begin
                    if (resp_req_i) begin
                        state_d = RESP;
                    end else if (wr_req_i && rd_req_i) begin
                        state_d = rr_rd_q ? RD : WR;
                    end else if (wr_req_i) begin
                        state_d = WR;
                    end else if (rd_req_i) begin
                        state_d = RD;
                    end
                end
            end
            WR, RD: begin
                // A pending response ends the burst; any beat accepted this cycle still counts.
                if ((accept && (burst_d == BURST_LAST)) || !gnt_req ||
                    (credit_d == '0) || resp_req_i) begin
                    state_d = IDLE;
                    rr_rd_d = (state_q == WR);
                end
            end
            RESP: begin
                if (accept || !resp_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ADAPTER_SCHED_STATS_EN
    logic [15:0] wr_beats_q, rd_beats_q, resp_beats_q, stall_cyc_q;
    logic        stall;

    assign stall = (wr_req_i || rd_req_i || resp_req_i) && (credit_q == '0) && (state_q == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            credit_q <= CRD_MAX;
            burst_q  <= '0;
            rr_rd_q  <= 1'b0;
`ifdef ADAPTER_SCHED_STATS_EN
            wr_beats_q   <= '0;
            rd_beats_q   <= '0;
            resp_beats_q <= '0;
            stall_cyc_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            burst_q  <= burst_d;
            rr_rd_q  <= rr_rd_d;
`ifdef ADAPTER_SCHED_STATS_EN
            if (stats_clr_i) begin
                wr_beats_q   <= '0;
                rd_beats_q   <= '0;
                resp_beats_q <= '0;
                stall_cyc_q  <= '0;
            end else begin
                if (accept && (state_q == WR) && (wr_beats_q != '1)) begin
                    wr_beats_q <= wr_beats_q + 1'b1;
                end
                if (accept && (state_q == RD) && (rd_beats_q != '1)) begin
                    rd_beats_q <= rd_beats_q + 1'b1;
                end
                if (accept && (state_q == RESP) && (resp_beats_q != '1)) begin
                    resp_beats_q <= resp_beats_q + 1'b1;
                end
                if (stall && (stall_cyc_q != '1)) begin
                    stall_cyc_q <= stall_cyc_q + 1'b1;
                end
            end
`endif
        end
    end

    assign wr_gnt_o      = (state_q == WR);
    assign rd_gnt_o      = (state_q == RD);
    assign resp_gnt_o    = (state_q == RESP);
    assign link_valid_o  = link_valid;
    assign credit_o      = credit_q;
    assign sched_state_o = state_q;

`ifdef ADAPTER_SCHED_STATS_EN
    assign wr_beats_o   = wr_beats_q;
    assign rd_beats_o   = rd_beats_q;
    assign resp_beats_o = resp_beats_q;
    assign stall_cyc_o  = stall_cyc_q;
`endif

endmodule

// File: tb/tb_adapter_link_sched.sv
// Bench for adapter_link_sched: vector table, directed corner sequences, random run vs reference model.
module tb_adapter_link_sched;

    localparam int CRD_INIT  = 127;
    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, enable = 1'b0;
    logic       wr_req_i = 1'b0, rd_req_i = 1'b0, resp_req_i = 1'b0;
    logic       link_ready_i = 1'b0, crd_return_i = 1'b0;
    logic       wr_gnt_o, rd_gnt_o, resp_gnt_o, link_valid_o;
    logic [6:0] credit_o;
    logic [1:0] sched_state_o;
`ifdef ADAPTER_SCHED_STATS_EN
    logic        stats_clr_i = 1'b0;
    logic [15:0] wr_beats_o, rd_beats_o, resp_beats_o, stall_cyc_o;
`endif

    always #5 clk = ~clk;

    adapter_link_sched #(.CRD_W(7), .CRD_INIT(CRD_INIT), .MAX_BURST(MAX_BURST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .wr_req_i     (wr_req_i),
        .rd_req_i     (rd_req_i),
        .resp_req_i   (resp_req_i),
        .link_ready_i (link_ready_i),
        .crd_return_i (crd_return_i),
`ifdef ADAPTER_SCHED_STATS_EN
        .stats_clr_i  (stats_clr_i),
        .wr_beats_o   (wr_beats_o),
        .rd_beats_o   (rd_beats_o),
        .resp_beats_o (resp_beats_o),
        .stall_cyc_o  (stall_cyc_o),
`endif
        .wr_gnt_o     (wr_gnt_o),
        .rd_gnt_o     (rd_gnt_o),
        .resp_gnt_o   (resp_gnt_o),
        .link_valid_o (link_valid_o),
        .credit_o     (credit_o),
        .sched_state_o(sched_state_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0 none, 1 wr, 2 rd, 3 resp; m_next is the wr/rd tie winner.
    bit model_ok = 1'b0;
    int m_owner, m_credit, m_beats, m_next;
    int m_wrb, m_rdb, m_rsb, m_stall;

    function automatic bit m_req(input int who);
        case (who)
            1:       return wr_req_i;
            2:       return rd_req_i;
            3:       return resp_req_i;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_valid();
        return (m_owner != 0) && m_req(m_owner) && (m_credit > 0);
    endfunction

    task automatic set_in(input bit r, input bit e, input bit w, input bit rd,
                          input bit rs, input bit rdy, input bit ret);
        @(negedge clk);
        rst_n = r; enable = e; wr_req_i = w; rd_req_i = rd; resp_req_i = rs;
        link_ready_i = rdy; crd_return_i = ret;
        #1;
        if (model_ok) begin
            check("state", 32'(sched_state_o), 32'(m_owner));
            check("grants", 32'({wr_gnt_o, rd_gnt_o, resp_gnt_o}),
                  32'({m_owner == 1, m_owner == 2, m_owner == 3}));
            check("link_valid", 32'(link_valid_o), 32'(m_valid()));
            check("credit", 32'(credit_o), 32'(m_credit));
`ifdef ADAPTER_SCHED_STATS_EN
            check("wr_beats", 32'(wr_beats_o), 32'(m_wrb));
            check("rd_beats", 32'(rd_beats_o), 32'(m_rdb));
            check("resp_beats", 32'(resp_beats_o), 32'(m_rsb));
            check("stall_cyc", 32'(stall_cyc_o), 32'(m_stall));
`endif
        end
    endtask

    task automatic tick();
        bit acc;
        bit done;
        int nc;
        @(posedge clk);
        if (!rst_n) begin
            m_owner = 0; m_credit = CRD_INIT; m_beats = 0; m_next = 1;
            m_wrb = 0; m_rdb = 0; m_rsb = 0; m_stall = 0;
            model_ok = 1'b1;
            return;
        end
        if (!model_ok) return;
        acc = m_valid() && link_ready_i;
`ifdef ADAPTER_SCHED_STATS_EN
        if (stats_clr_i) begin
            m_wrb = 0; m_rdb = 0; m_rsb = 0; m_stall = 0;
        end else begin
            if (acc && m_owner == 1 && m_wrb < 65535) m_wrb++;
            if (acc && m_owner == 2 && m_rdb < 65535) m_rdb++;
            if (acc && m_owner == 3 && m_rsb < 65535) m_rsb++;
            if ((wr_req_i || rd_req_i || resp_req_i) && m_credit == 0 && m_owner == 0 &&
                m_stall < 65535) m_stall++;
        end
`endif
        nc = m_credit - int'(acc) + int'(crd_return_i);
        if (nc > CRD_INIT) nc = CRD_INIT;
        case (m_owner)
            0: begin
                m_beats = 0;
                if (enable && m_credit > 0) begin
                    if (resp_req_i)                 m_owner = 3;
                    else if (wr_req_i && rd_req_i)  m_owner = m_next;
                    else if (wr_req_i)              m_owner = 1;
                    else if (rd_req_i)              m_owner = 2;
                end
            end
            3: if (acc || !resp_req_i) m_owner = 0;
            default: begin
                if (acc) m_beats++;
                done = (acc && m_beats == MAX_BURST) || !m_req(m_owner) || nc == 0 || resp_req_i;
                if (done) begin
                    m_next  = (m_owner == 1) ? 2 : 1;
                    m_owner = 0;
                end
            end
        endcase
        m_credit = nc;
    endtask

    typedef struct {
        bit r, e, w, rd, rs, rdy, ret;
        bit chk;
        int st;
        int crd;
        bit vld;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit e, input bit w, input bit rd, input bit rs,
                       input bit rdy, input bit ret, input bit chk, input int st,
                       input int crd, input bit vld);
        vec_t v;
        v.r = r; v.e = e; v.w = w; v.rd = rd; v.rs = rs; v.rdy = rdy; v.ret = ret;
        v.chk = chk; v.st = st; v.crd = crd; v.vld = vld;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        // Single requester: WR burst of four, IDLE turnaround, WR again.
        add(0,0,0,0,0,0,0, 0, 0,   0, 0);
        add(1,1,1,0,0,1,0, 1, 0, 127, 0);
        add(1,1,1,0,0,1,0, 1, 1, 127, 1);
        add(1,1,1,0,0,1,0, 1, 1, 126, 1);
        add(1,1,1,0,0,1,0, 1, 1, 125, 1);
        add(1,1,1,0,0,1,0, 1, 1, 124, 1);
        add(1,1,1,0,0,1,0, 1, 0, 123, 0);
        add(1,1,1,0,0,1,0, 1, 1, 123, 1);
        // Both requesters: alternation WR, IDLE, RD, IDLE, WR.
        add(0,0,0,0,0,0,0, 0, 0,   0, 0);
        add(1,1,1,1,0,1,0, 1, 0, 127, 0);
        add(1,1,1,1,0,1,0, 1, 1, 127, 1);
        add(1,1,1,1,0,1,0, 1, 1, 126, 1);
        add(1,1,1,1,0,1,0, 1, 1, 125, 1);
        add(1,1,1,1,0,1,0, 1, 1, 124, 1);
        add(1,1,1,1,0,1,0, 1, 0, 123, 0);
        add(1,1,1,1,0,1,0, 1, 2, 123, 1);
        add(1,1,1,1,0,1,0, 1, 2, 122, 1);
        add(1,1,1,1,0,1,0, 1, 2, 121, 1);
        add(1,1,1,1,0,1,0, 1, 2, 120, 1);
        add(1,1,1,1,0,1,0, 1, 0, 119, 0);
        add(1,1,1,1,0,1,0, 1, 1, 119, 1);
        add(1,1,1,1,0,1,0, 1, 1, 118, 1);
        add(1,1,1,1,0,1,0, 1, 1, 117, 1);
        add(1,1,1,1,0,1,0, 1, 1, 116, 1);
        add(1,1,1,1,0,1,0, 1, 0, 115, 0);
        add(1,1,1,1,0,1,0, 1, 2, 115, 1);
        add(1,1,1,1,0,1,0, 1, 2, 114, 1);
        // Reset two beats into an RD burst.
        add(0,1,1,1,0,1,0, 1, 2, 113, 1);
        add(1,0,0,0,0,0,0, 1, 0, 127, 0);
        // Return at full credit is dropped.
        add(1,1,0,0,0,0,1, 1, 0, 127, 0);
        add(1,1,0,0,0,0,0, 1, 0, 127, 0);

        foreach (tbl[i]) begin
            set_in(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].rd, tbl[i].rs, tbl[i].rdy, tbl[i].ret);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_state", i), 32'(sched_state_o), 32'(tbl[i].st));
                check($sformatf("tbl%0d_credit", i), 32'(credit_o), 32'(tbl[i].crd));
                check($sformatf("tbl%0d_valid", i), 32'(link_valid_o), 32'(tbl[i].vld));
            end
            tick();
        end

        // Drain all credit, then one returned credit buys exactly one beat.
        do_reset();
        for (int i = 0; i < 400 && !(m_credit == 0 && m_owner == 0); i++) begin
            set_in(1, 1, 1, 0, 0, 1, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 0, 0, 1, 0);
            check("drain_credit", 32'(credit_o), 0);
            check("drain_state", 32'(sched_state_o), 0);
            check("drain_valid", 32'(link_valid_o), 0);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 1, 1);
        check("ret_pulse_state", 32'(sched_state_o), 0);
        tick();
        set_in(1, 1, 1, 0, 0, 1, 0);
        check("ret_credit1", 32'(credit_o), 1);
        tick();
        set_in(1, 1, 1, 0, 0, 1, 0);
        check("ret_grant", 32'(sched_state_o), 1);
        check("ret_valid", 32'(link_valid_o), 1);
        tick();
        set_in(1, 1, 1, 0, 0, 1, 0);
        check("ret_credit0", 32'(credit_o), 0);
        check("ret_idle", 32'(sched_state_o), 0);
        tick();

        // Response interrupts a WR burst after two beats.
        do_reset();
        set_in(1, 1, 1, 0, 0, 1, 0); check("int_idle0", 32'(sched_state_o), 0); tick();
        set_in(1, 1, 1, 0, 0, 1, 0); check("int_wr", 32'(sched_state_o), 1); tick();
        set_in(1, 1, 1, 0, 0, 1, 0); tick();
        set_in(1, 1, 1, 0, 1, 1, 0);
        check("int_beat3_valid", 32'(link_valid_o), 1);
        tick();
        set_in(1, 1, 1, 0, 1, 1, 0);
        check("int_idle_state", 32'(sched_state_o), 0);
        check("int_idle_credit", 32'(credit_o), 124);
        tick();
        set_in(1, 1, 1, 0, 1, 1, 0);
        check("int_resp_state", 32'(sched_state_o), 3);
        check("int_resp_gnt", 32'(resp_gnt_o), 1);
        tick();
        set_in(1, 1, 1, 1, 0, 1, 0);
        check("int_after_resp", 32'(sched_state_o), 0);
        check("int_after_credit", 32'(credit_o), 123);
        tick();
        set_in(1, 1, 1, 1, 0, 1, 0);
        check("rr_ptr_rd", 32'(sched_state_o), 2);
        tick();

        // Accept and return in the same cycle at credit 50.
        do_reset();
        for (int i = 0; i < 300 && m_credit > 50; i++) begin
            set_in(1, 1, 1, 0, 0, 1, 0);
            tick();
        end
        if (m_owner != 1) begin
            set_in(1, 1, 1, 0, 0, 1, 0);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 1, 1);
        check("both_valid", 32'(link_valid_o), 1);
        check("both_before", 32'(credit_o), 50);
        tick();
        set_in(1, 1, 0, 0, 0, 1, 0);
        check("both_after", 32'(credit_o), 50);
        tick();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
`ifdef ADAPTER_SCHED_STATS_EN
            stats_clr_i = ($urandom_range(0, 199) == 0);
`endif
            set_in($urandom_range(0, 399) != 0,
                   $urandom_range(0, 9) != 0,
                   $urandom_range(0, 2) != 0,
                   $urandom_range(0, 2) != 0,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 99) < ((i < 1500) ? 15 : 55));
            tick();
        end
`ifdef ADAPTER_SCHED_STATS_EN
        stats_clr_i = 1'b0;
`endif
        set_in(1, 0, 0, 0, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
